div_sched_ctrl: RTL and testbench

- Run/pause/stop controller and tick scheduler for the board's programmable frequency divider.
- Owns the divide counter and the active divisor register.
- Emits a one-cycle tick strobe plus a toggled slow clock.
- Accepts runtime divisor changes through a req/ack handshake, applied only at period boundaries so there are no glitches.
- Sits between the push-button/FSM layer and downstream counters and displays.

---
 rtl/div_sched_ctrl.sv | 174 +++++++++++++++++
 tb/tb_div_sched_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/div_sched_ctrl.sv
// Run/pause/stop controller and tick scheduler for the frequency divider.
// Optional one-shot mode (shot_len/done ports) enabled by DIVCTRL_ONESHOT_EN.
module div_sched_ctrl #(
    parameter int CNT_W   = 23,
    parameter int DEF_DIV = 5000000,
    parameter int TCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              div_req,
`ifdef DIVCTRL_ONESHOT_EN
    input  logic [TCNT_W-1:0] shot_len,
    output logic              done,
`endif
    output logic              div_ack,
    output logic              cfg_err,
    output logic              tick,
    output logic              clk_out,
    output logic              running,
    output logic [TCNT_W-1:0] tick_count
);

    localparam logic [CNT_W-1:0] DEF_Q = CNT_W'(DEF_DIV);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [CNT_W-1:0]    r_div_q, w_div_q;
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt;
    logic                r_tick, w_tick;
    logic                r_clk, w_clk;
    logic                r_ack, w_ack;
    logic                r_err, w_err;
    logic                r_run;
    logic                w_req, w_wrap, w_bad, w_take;
`ifdef DIVCTRL_ONESHOT_EN
    logic [TCNT_W-1:0]   r_shot, w_shot;
    logic                r_done, w_done;
`endif

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_div_q = r_div_q;
        w_tcnt  = r_tcnt;
        w_tick  = 1'b0;
        w_clk   = r_clk;
        w_ack   = 1'b0;
        w_err   = 1'b0;
        w_take  = 1'b0;
`ifdef DIVCTRL_ONESHOT_EN
        w_shot  = r_shot;
        w_done  = 1'b0;
`endif
        // a request is never re-consumed in the cycle its ack is visible
        w_req   = div_req && !r_ack;
        w_bad   = div_val < CNT_W'(2);
        w_wrap  = r_cnt == r_div_q - CNT_W'(1);
        if (stop) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_clk   = 1'b0;
            w_tcnt  = '0;
            w_take  = w_req;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_take = w_req;
                    if (start) begin
                        w_state = S_RUN;
                        w_clk   = 1'b0;
                        w_tcnt  = '0;
`ifdef DIVCTRL_ONESHOT_EN
                        w_shot  = shot_len;
`endif
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state = S_PAUSE;
                    end else if (w_wrap) begin
                        w_cnt  = '0;
                        w_tick = 1'b1;
                        w_clk  = ~r_clk;
                        w_tcnt = r_tcnt + TCNT_W'(1);
                        w_take = w_req;
`ifdef DIVCTRL_ONESHOT_EN
                        if (r_shot != '0) begin
                            w_shot = r_shot - TCNT_W'(1);
                            if (r_shot == TCNT_W'(1)) begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                            end
                        end
`endif
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    // a new divisor restarts the period from zero
                    if (w_req) begin
                        w_take = 1'b1;
                        w_cnt  = '0;
                    end
                    if (start) w_state = S_RUN;
                end
                default: w_state = S_IDLE;
            endcase
        end
        if (w_take) begin
            w_ack = 1'b1;
            w_err = w_bad;
            if (!w_bad) w_div_q = div_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_run   <= w_state == S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div_q <= DEF_Q;
            r_tcnt  <= '0;
            r_tick  <= 1'b0;
            r_clk   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt;
            r_div_q <= w_div_q;
            r_tcnt  <= w_tcnt;
            r_tick  <= w_tick;
            r_clk   <= w_clk;
            r_ack   <= w_ack;
            r_err   <= w_err;
        end
    end

`ifdef DIVCTRL_ONESHOT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shot <= '0;
            r_done <= 1'b0;
        end else begin
            r_shot <= w_shot;
            r_done <= w_done;
        end
    end

    assign done = r_done;
`endif

    assign div_ack    = r_ack;
    assign cfg_err    = r_err;
    assign tick       = r_tick;
    assign clk_out    = r_clk;
    assign running    = r_run;
    assign tick_count = r_tcnt;

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed bench for div_sched_ctrl with DEF_DIV=4 and a 2-bit tick counter.
// Exercises the one-shot ports as well when DIVCTRL_ONESHOT_EN is defined.
module tb_div_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] div_val = '0;
    logic       div_req = 1'b0;
    logic       div_ack, cfg_err, tick, clk_out, running;
    logic [1:0] tick_count;
`ifdef DIVCTRL_ONESHOT_EN
    logic [1:0] shot_len = '0;
    logic       done;
`endif

    int checks = 0;
    int errors = 0;

    div_sched_ctrl #(
        .CNT_W  (8),
        .DEF_DIV(4),
        .TCNT_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .div_val   (div_val),
        .div_req   (div_req),
`ifdef DIVCTRL_ONESHOT_EN
        .shot_len  (shot_len),
        .done      (done),
`endif
        .div_ack   (div_ack),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .clk_out   (clk_out),
        .running   (running),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_tick", tick, 0);
        chk("rst_clk", clk_out, 0);
        chk("rst_tcnt", tick_count, 0);
        chk("rst_ack", {div_ack, cfg_err}, 0);
        chk("rst_run", running, 0);

        // free run, ticks 4 cycles apart
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("run_on", running, 1);
        step(3);
        chk("t1_early", tick, 0);
        step(1);
        chk("t1", {tick, clk_out, tick_count}, 4'b1101);
        step(1);
        chk("t1_pulse", tick, 0);
        step(3);
        chk("t2", {tick, clk_out, tick_count}, 4'b1010);
        step(4);
        chk("t3", {tick, clk_out, tick_count}, 4'b1111);
        step(4);
        chk("t4_wrap", {tick, clk_out, tick_count}, 4'b1000);

        // pause at cnt=1, resume after 10 idle cycles
        step(1);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("paused", running, 0);
        step(10);
        chk("pause_hold", {tick, clk_out, tick_count}, 4'b0000);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("resumed", running, 1);
        step(2);
        chk("res_early", tick, 0);
        step(1);
        chk("res_tick", {tick, clk_out, tick_count}, 4'b1101);

        // divisor change to 6 while running
        step(1);
        div_val = 8'd6;
        div_req = 1'b1;
        step(2);
        chk("pend_noack", div_ack, 0);
        step(1);
        chk("chg_tick", {tick, div_ack, cfg_err}, 3'b110);
        chk("chg_state", {clk_out, tick_count}, 3'b010);
        step(1);
        chk("ack_once", div_ack, 0);
        div_req = 1'b0;
        step(4);
        chk("p6_early", tick, 0);
        step(1);
        chk("p6_tick", {tick, clk_out, tick_count}, 4'b1111);

        // reset mid-period with a request pending
        div_val = 8'd3;
        div_req = 1'b1;
        step(2);
        rst = 1'b1;
        div_req = 1'b0;
        step(1);
        rst = 1'b0;
        chk("rst2", {tick, clk_out, tick_count, running}, 5'b0);
        for (int i = 0; i < 8; i++) begin
            chk("rst2_noack", div_ack, 0);
            step(1);
        end

        // stop+pause+start together while running
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        chk("pre_stop", {running, tick_count}, 3'b101);
        stop = 1'b1;
        pause = 1'b1;
        start = 1'b1;
        step(1);
        {stop, pause, start} = 3'b000;
        chk("stopped", {running, clk_out, tick_count, tick}, 5'b0);

        // rejected divisor in IDLE
        div_val = 8'd1;
        div_req = 1'b1;
        step(1);
        chk("rej", {div_ack, cfg_err}, 2'b11);
        step(1);
        div_req = 1'b0;
        chk("rej_once", {div_ack, cfg_err}, 2'b00);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk("p4_early", tick, 0);
        step(1);
        chk("p4_tick", {tick, tick_count}, 3'b101);

`ifdef DIVCTRL_ONESHOT_EN
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        shot_len = 2'd3;
        start = 1'b1;
        step(1);
        start = 1'b0;
        shot_len = 2'd0;
        step(4);
        chk("os_t1", {tick, done, running}, 3'b101);
        step(4);
        chk("os_t2", {tick, done, running}, 3'b101);
        step(4);
        chk("os_t3", {tick, done, running, tick_count}, 5'b11011);
        step(1);
        chk("os_idle", {tick, done, running, clk_out}, 4'b0001);
        step(4);
        chk("os_hold", {tick, running, clk_out}, 3'b001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
